sram_arbiter: RTL
=================

SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 SHALL have parameter: RR_EN, default 1, 1 = alternate grant on simultaneous requests, 0 = data side always wins.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: resetn  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have ports: inst_req  input  1; inst_addr  input  32; inst_addr_ok  output  1; inst_data_ok  output  1; inst_rdata  output  32.
REQ-005 SHALL have ports: data_req  input  1; data_wr  input  1; data_size  input  2; data_wstrb  input  4; data_addr  input  32; data_wdata  input  32; data_addr_ok  output  1; data_data_ok  output  1; data_rdata  output  32.
REQ-006 SHALL have ports: mem_req  output  1; mem_wr  output  1; mem_size  output  2; mem_wstrb  output  4; mem_addr  output  32; mem_wdata  output  32; mem_addr_ok  input  1; mem_data_ok  input  1; mem_rdata  input  32.

Function
REQ-007 SHALL share the single mem port between the instruction and data requesters, with at most one transaction outstanding.
REQ-008 SHALL implement FSM states IDLE, ADDR, DATA; reset state IDLE.
REQ-009 In IDLE with any request present, SHALL select a winner, latch its wr/size/wstrb/addr/wdata into registers, pulse that requester's addr_ok for exactly that cycle, and enter ADDR next cycle.
REQ-010 Arbitration: single requester wins; if both request and RR_EN=1, the side not granted last wins; with RR_EN=0, or no prior grant since reset, data wins.
REQ-011 Instruction transactions SHALL be latched as wr=0, size=2'b10, wstrb=4'b0000, wdata=0.
REQ-012 In ADDR, SHALL drive mem_req=1 with the latched fields, held stable until mem_addr_ok=1; on that edge SHALL enter DATA.
REQ-013 In DATA, mem_req SHALL be 0; on mem_data_ok=1 SHALL pulse the granted side's data_ok for that same cycle and return to IDLE next cycle.
REQ-014 During the data_ok pulse, the granted side's rdata SHALL equal mem_rdata combinationally; it SHALL be 0 at all other times.
REQ-015 The non-granted side's addr_ok and data_ok SHALL stay 0 throughout a transaction; its request SHALL remain pending, not lost.
REQ-016 mem_addr_ok outside ADDR and mem_data_ok outside DATA SHALL be ignored.
REQ-017 A request arriving while in ADDR or DATA SHALL NOT be accepted until the next IDLE cycle; minimum turnaround is 3 cycles per transaction.
REQ-018 last-grant SHALL update only on acceptance in IDLE.
REQ-019 mem_addr_ok and mem_data_ok asserted together in ADDR SHALL complete only the address phase; data_ok SHALL be taken in DATA.

Reset
REQ-020 resetn=0 SHALL asynchronously force IDLE, clear latched fields and last-grant, and drive all outputs to 0.
REQ-021 Reset mid-transaction SHALL abandon it with no data_ok issued; after release, the first transaction SHALL follow REQ-010 as if fresh.

Verification
REQ-022 Reset: resetn=0 for 3 cycles with both requests high -> all outputs 0; release -> data_addr_ok=1 in first cycle, inst_addr_ok=0.
REQ-023 Inst fetch: inst_req=1, addr=0x1c000000; mem_addr_ok after 1 cycle; mem_data_ok with rdata=0x02800c0c after 2 cycles -> mem_addr=0x1c000000, mem_wr=0, inst_data_ok=1 with inst_rdata=0x02800c0c.
REQ-024 Store: data_req=1, wr=1, size=2, wstrb=0xF, addr=0x1c008000, wdata=0xdeadbeef -> identical mem fields held until mem_addr_ok, then data_data_ok on mem_data_ok.
REQ-025 Contention, RR_EN=1, both held high for 4 transactions -> grant order data, inst, data, inst; with RR_EN=0 -> data four times.
REQ-026 Backpressure: mem_addr_ok held 0 for 5 cycles -> mem_req and fields stable all 5 cycles; spurious mem_data_ok in ADDR -> no data_ok.
REQ-027 Reset asserted in DATA -> no data_ok; the next transaction after release completes normally.

Source files
------------

// File: rtl/sram_arbiter.sv
// sram_arbiter: shares one SRAM-like mem port between an instruction and a
// data requester. One transaction is in flight at a time: IDLE -> ADDR -> DATA.
//
// Ports
//   clk, resetn      : clock, async active-low reset
//   inst_*           : instruction requester (read-only, word fetch)
//   data_*           : data requester (read/write, size + byte strobes)
//   mem_*            : shared memory port (addr handshake, then data handshake)
module sram_arbiter #(
  parameter bit RR_EN = 1'b1
) (
  input  logic        clk,
  input  logic        resetn,

  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,

  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,

  output logic        mem_req,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_e;

  state_e      state_q, state_d;

  // Side owning the current transaction (1 = data).
  logic        gnt_data_q, gnt_data_d;

  // Last accepted grant; last_vld_q is 0 until the first acceptance.
  logic        last_vld_q, last_vld_d;
  logic        last_data_q, last_data_d;

  logic        wr_q, wr_d;
  logic [1:0]  size_q, size_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;

  logic        any_req;
  logic        pick_data;
  logic        accept;
  logic        done;
  logic        in_addr;

  assign any_req = inst_req | data_req;

  // Data wins unless inst is alone, or round-robin says inst's turn:
  // both requesting, RR enabled, and data took the previous grant.
  assign pick_data = data_req &
                     (~inst_req | ~RR_EN | ~last_vld_q | ~last_data_q);

  assign accept  = (state_q == IDLE) & any_req;
  assign done    = (state_q == DATA) & mem_data_ok;
  assign in_addr = (state_q == ADDR);

  // ---------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (any_req)     state_d = ADDR;
      ADDR: if (mem_addr_ok) state_d = DATA;
      DATA: if (mem_data_ok) state_d = IDLE;
      default:               state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------
  // Transaction / arbitration registers
  // ---------------------------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      gnt_data_q  <= 1'b0;
      last_vld_q  <= 1'b0;
      last_data_q <= 1'b0;
      wr_q        <= 1'b0;
      size_q      <= 2'b00;
      wstrb_q     <= 4'b0000;
      addr_q      <= 32'h0;
      wdata_q     <= 32'h0;
    end else begin
      gnt_data_q  <= gnt_data_d;
      last_vld_q  <= last_vld_d;
      last_data_q <= last_data_d;
      wr_q        <= wr_d;
      size_q      <= size_d;
      wstrb_q     <= wstrb_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
    end
  end

  always_comb begin
    gnt_data_d  = gnt_data_q;
    last_vld_d  = last_vld_q;
    last_data_d = last_data_q;
    wr_d        = wr_q;
    size_d      = size_q;
    wstrb_d     = wstrb_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    if (accept) begin
      gnt_data_d  = pick_data;
      last_vld_d  = 1'b1;
      last_data_d = pick_data;
      if (pick_data) begin
        wr_d    = data_wr;
        size_d  = data_size;
        wstrb_d = data_wstrb;
        addr_d  = data_addr;
        wdata_d = data_wdata;
      end else begin
        // Fetches are always full-word reads.
        wr_d    = 1'b0;
        size_d  = 2'b10;
        wstrb_d = 4'b0000;
        addr_d  = inst_addr;
        wdata_d = 32'h0;
      end
    end
  end

  // ---------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------
  always_comb begin
    // resetn gates addr_ok: requests may be high while reset is held.
    inst_addr_ok = resetn & accept & ~pick_data;
    data_addr_ok = resetn & accept & pick_data;

    inst_data_ok = done & ~gnt_data_q;
    data_data_ok = done & gnt_data_q;

    inst_rdata   = inst_data_ok ? mem_rdata : 32'h0;
    data_rdata   = data_data_ok ? mem_rdata : 32'h0;

    mem_req      = in_addr;
    mem_wr       = in_addr & wr_q;
    mem_size     = in_addr ? size_q  : 2'b00;
    mem_wstrb    = in_addr ? wstrb_q : 4'b0000;
    mem_addr     = in_addr ? addr_q  : 32'h0;
    mem_wdata    = in_addr ? wdata_q : 32'h0;
  end

endmodule
